// File: rtl/qam16_hard_demap.sv
// rtl/qam16_hard_demap.sv - hard-decision Gray QAM16 demapper emitting one burst per tx_done handshake.
// Optional saturating sync-error counter port err_cnt is built when QAM16_DEMAP_ERRCNT_EN is defined.
module qam16_hard_demap #(
  parameter int W          = 16,
  parameter int THR        = 2048,
  parameter int N_BIN      = 32,
  parameter int ACT_START  = 1,
  parameter int ACT_NUM    = 28,
  parameter int SYMBOL_NUM = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_in,
  input  logic [W-1:0] q_in,
  input  logic         in_valid,
  input  logic         sym_start,
  input  logic         tx_done,
  output logic [3:0]   dout,
  output logic         dout_valid,
  output logic         burst_done,
  output logic         sync_err
`ifdef QAM16_DEMAP_ERRCNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);

  localparam int BW      = (N_BIN > 1) ? $clog2(N_BIN) : 1;
  localparam int NIB_TOT = ACT_NUM * SYMBOL_NUM;
  localparam int NW      = $clog2(NIB_TOT + 1);

  localparam logic [BW-1:0] BIN_LAST  = BW'(N_BIN - 1);
  localparam logic [NW-1:0] NIB_LAST  = NW'(NIB_TOT - 1);
  localparam logic [NW-1:0] NIB_LIMIT = NW'(NIB_TOT);
  localparam logic [31:0]   ACT_LO    = 32'(ACT_START);
  localparam logic [31:0]   ACT_HI    = 32'(ACT_START + ACT_NUM);

  localparam logic signed [W:0] THR_P = (W+1)'(THR);
  localparam logic signed [W:0] THR_N = (W+1)'(-THR);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [BW-1:0] bin_cnt;
  logic [7:0]    sym_cnt;
  logic [NW-1:0] nib_cnt;

  logic          take;
  logic          misalign;
  logic          active;
  logic [BW-1:0] eff_bin;
  logic [31:0]   eff_bin_w;

  logic signed [W:0] i_ext;
  logic signed [W:0] q_ext;
  logic [3:0]        slice;

  logic       s1_valid;
  logic [3:0] s1_bits;

  // Sign-extend by one bit so the most negative input compares correctly without abs().
  assign i_ext = {i_in[W-1], i_in};
  assign q_ext = {q_in[W-1], q_in};

  always_comb begin
    slice[3] = ~i_in[W-1];
    slice[2] = (i_ext > THR_N) && (i_ext < THR_P);
    slice[1] = ~q_in[W-1];
    slice[0] = (q_ext > THR_N) && (q_ext < THR_P);
  end

  // A sample is consumed in IDLE only when it opens a symbol; DONE swallows everything.
  always_comb begin
    take     = 1'b0;
    misalign = 1'b0;
    eff_bin  = bin_cnt;
    if (!tx_done && in_valid) begin
      case (state)
        ST_IDLE: begin
          if (sym_start) begin
            take    = 1'b1;
            eff_bin = '0;
          end
        end
        ST_RUN: begin
          take = 1'b1;
          if (sym_start && (bin_cnt != '0)) begin
            misalign = 1'b1;
            eff_bin  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign eff_bin_w = 32'(eff_bin);
  assign active    = take && (eff_bin_w >= ACT_LO) && (eff_bin_w < ACT_HI)
                     && (nib_cnt < NIB_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bin_cnt  <= '0;
      sym_cnt  <= '0;
      nib_cnt  <= '0;
      sync_err <= 1'b0;
    end else if (tx_done) begin
      state    <= ST_IDLE;
      bin_cnt  <= '0;
      sym_cnt  <= '0;
      nib_cnt  <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= misalign;
      if (take) begin
        bin_cnt <= (eff_bin == BIN_LAST) ? '0 : eff_bin + 1'b1;
        if (misalign || (eff_bin == BIN_LAST)) begin
          sym_cnt <= sym_cnt + 8'd1;
        end
        if (state == ST_IDLE) begin
          state <= ST_RUN;
        end
        if (active) begin
          nib_cnt <= nib_cnt + 1'b1;
          if (nib_cnt == NIB_LAST) begin
            state <= ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_bits  <= 4'd0;
    end else if (tx_done) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= active;
      if (active) begin
        s1_bits <= slice;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 4'd0;
      dout_valid <= 1'b0;
    end else if (tx_done) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        dout <= s1_bits;
      end
    end
  end

  assign burst_done = (state == ST_DONE);

`ifdef QAM16_DEMAP_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (tx_done) begin
      err_cnt <= 8'd0;
    end else if (misalign && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/qam16_hard_demap.md
Name: qam16_hard_demap

Overview:
- Hard-decision QAM16 demapper placed directly upstream of the receive output buffer.
- Takes equalised I/Q frequency bins of each OFDM symbol and keeps only the active subcarriers.
- Slices each active bin to a Gray-coded 4-bit nibble and emits exactly one burst of ACT_NUM*SYMBOL_NUM nibbles with a valid strobe.
- Holds off after the burst until tx_done re-arms it, matching the downstream buffer's burst protocol.

Parameters:
- W, 16, signed width of I and Q samples.
- THR, 2048, inner/outer slicing threshold (2x the nominal unit amplitude of 1024).
- N_BIN, 32, bins per OFDM symbol at the input.
- ACT_START, 1, index of the first active bin.
- ACT_NUM, 28, number of consecutive active bins per symbol.
- SYMBOL_NUM, 8, data symbols per burst.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_in  in  W  signed in-phase sample.
- q_in  in  W  signed quadrature sample.
- in_valid  in  1  sample qualifier, one bin per valid cycle.
- sym_start  in  1  marks bin 0 of an OFDM symbol; only sampled when in_valid=1.
- tx_done  in  1  burst consumed downstream; re-arms the block.
- dout  out  4  demapped nibble {b3,b2,b1,b0}.
- dout_valid  out  1  one-cycle strobe per nibble.
- burst_done  out  1  level, high in state DONE.
- sync_err  out  1  one-cycle pulse on misaligned sym_start.

Behaviour:
- Reset values:
  - dout=0, dout_valid=0, burst_done=0, sync_err=0.
  - State=IDLE; bin_cnt, sym_cnt, nib_cnt and the pipeline valids all cleared.
- Slicing (Gray mapping: -3→00, -1→01, +1→11, +3→10):
  - b3 = (I >= 0).
  - b2 = (I > -THR) && (I < THR).
  - b1 and b0 are derived identically from Q.
  - Exactly ±THR counts as outer.
  - Comparisons are signed, done in W+1 bits; no abs() is used, so -2^(W-1) is handled correctly.
- Pipeline:
  - Stage 1 registers the comparison results plus an "active" flag.
  - Stage 2 registers dout and dout_valid.
  - Latency is 2 clk from the accepted in_valid cycle to dout_valid. Throughput is 1 bin/clk.
- Bin counter:
  - Advances on in_valid in RUN; wraps N_BIN-1 → 0.
  - A bin is active when ACT_START <= bin < ACT_START+ACT_NUM.
  - When bin_cnt wraps to 0, sym_cnt increments.
- State machine:
  - IDLE: wait for in_valid && sym_start. That sample is bin 0; move to RUN.
  - RUN: demap active bins.
    - When nib_cnt reaches ACT_NUM*SYMBOL_NUM (224) on the issuing cycle, go to DONE.
    - Non-active bins and any bins after the 224th nibble produce no output.
  - DONE: burst_done=1; all input is ignored; stay until tx_done.
- tx_done:
  - In any state, go to IDLE next cycle.
  - Clear counters, and clear the pipeline valids so no dout_valid issues after tx_done.
  - tx_done has priority over a simultaneous in_valid.
- Misaligned symbol start (sym_start && in_valid in RUN while bin_cnt != 0):
  - Pulse sync_err one cycle later.
  - Force that sample to bin 0 and start a new symbol (sym_cnt+1).
  - Nibbles already emitted are not retracted.
- sym_start with bin_cnt == 0 in RUN is normal, with no error.
- in_valid=0: counters and state hold; pipeline stages drain normally.
- dout holds its last value while dout_valid=0.
- rst_n asserted mid-burst: immediately return to the reset values above, independent of clk.

Optional Feature:
- Macro: QAM16_DEMAP_ERRCNT_EN.
- When defined:
  - Adds output port err_cnt [7:0]: a saturating count of sync_err events (holds at 255).
  - Cleared by rst_n or tx_done.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then sym_start + 32 bins, every bin I=+3072, Q=-3072 → 28 strobes with dout=4'b1000, first strobe 2 clk after bin 1 is accepted, none for bins 0 and 29-31.
- Threshold edges:
  - I=2048, Q=2047 → 4'b1011.
  - I=-2048, Q=-1 → 4'b0001.
  - I=-32768, Q=0 → 4'b0011.
- Full burst of 8 symbols plus 2 extra symbols → exactly 224 strobes; burst_done rises after the 224th; the extra bins produce nothing.
- tx_done asserted in DONE, then a new sym_start → burst_done falls and a fresh 224-nibble burst is delivered.
- sym_start at bin 10 of symbol 3 → sync_err pulse; that sample is treated as bin 0; the total burst is still 224 nibbles; with QAM16_DEMAP_ERRCNT_EN, err_cnt=1.
- rst_n pulsed low at nibble 100, and separately tx_done coinciding with an in_valid active bin → outputs return to reset values; no dout_valid follows tx_done.
